posit_encoder_pipe: RTL and testbench

- Pipelined posit packer: the inverse of the decode-side leading-bit/regime detection.
- Takes an unpacked posit (sign, signed regime k, exponent, fraction, sticky, zero/NaR flags) and produces the N-bit posit.
- Generates the regime run, concatenates exponent and fraction, rounds to nearest even, saturates, and applies two's-complement sign.
- Sits at the output of the optimised adder datapath; two-stage valid/ready pipeline.

---
 rtl/posit_encoder_pipe.sv | 121 ++++++++++++
 tb/tb_posit_encoder_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/posit_encoder_pipe.sv
// Two-stage posit packer: builds the regime run and the kept/guard/sticky split in stage 1,
// then rounds to nearest even, applies saturation and special values, and negates in stage 2.
module posit_encoder_pipe #(
  parameter int N  = 8,
  parameter int ES = 1,
  parameter int RS = $clog2(N),
  parameter int FW = N - 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic          in_zero,
  input  logic          in_nar,
  input  logic [RS:0]   in_k,
  input  logic [ES-1:0] in_exp,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);
  // Body is wide enough that the longest unsaturated regime plus exp/frac never falls off the end.
  localparam int BW = N + 1 + ES + FW;
  localparam int TW = BW - N;

  typedef struct packed {
    logic         sign;
    logic         zero;
    logic         nar;
    logic         sat_hi;
    logic         sat_lo;
    logic         guard;
    logic         sticky;
    logic [N-2:0] keep;
  } s1_t;

  logic         s1_valid, s2_valid, adv2;
  s1_t          s1_d, s1_q;
  logic [N-1:0] res;

  assign adv2      = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || adv2;
  assign out_valid = s2_valid;

  logic          k_neg;
  logic [RS:0]   kmag;
  logic [RS+1:0] rlen, ones_sh;
  logic [BW-1:0] regime, tail, body;
  int            kval;

  always_comb begin
    s1_d    = '0;
    kval    = int'($signed(in_k));
    k_neg   = in_k[RS];
    kmag    = k_neg ? (~in_k + (RS+1)'(1)) : in_k;
    rlen    = {1'b0, kmag} + (k_neg ? (RS+2)'(1) : (RS+2)'(2));
    ones_sh = {1'b0, kmag} + (RS+2)'(1);
    // k>=0: k+1 ones with an implicit terminating zero; k<0: -k zeros then a one.
    regime  = k_neg ? ({1'b1, {(BW-1){1'b0}}} >> kmag) : ~({BW{1'b1}} >> ones_sh);
    tail    = {in_exp, in_frac, {(BW-ES-FW){1'b0}}} >> rlen;
    body    = regime | tail;

    s1_d.sign   = in_sign;
    s1_d.zero   = in_zero;
    s1_d.nar    = in_nar;
    s1_d.sat_hi = kval >= (N - 2);
    s1_d.sat_lo = kval <= -(N - 2);
    s1_d.keep   = body[BW-1 -: N-1];
    s1_d.guard  = body[TW];
    s1_d.sticky = (|body[TW-1:0]) | in_sticky;
  end

  logic         rup;
  logic [N-1:0] sum;
  logic [N-2:0] mag;
  logic [N-1:0] word;

  always_comb begin
    rup = s1_q.guard && (s1_q.keep[0] || s1_q.sticky);
    sum = {1'b0, s1_q.keep} + N'(rup);
    mag = sum[N-1] ? '1 : sum[N-2:0];
    // A nonzero value never rounds down to zero.
    if (mag == '0)
      mag = {{(N-2){1'b0}}, 1'b1};

    if (s1_q.nar)
      word = {1'b1, {(N-1){1'b0}}};
    else if (s1_q.zero)
      word = '0;
    else if (s1_q.sat_hi)
      word = {1'b0, {(N-1){1'b1}}};
    else if (s1_q.sat_lo)
      word = {{(N-1){1'b0}}, 1'b1};
    else
      word = {1'b0, mag};

    res = (s1_q.sign && !s1_q.zero && !s1_q.nar) ? (~word + N'(1)) : word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s1_q      <= '0;
      out_posit <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid)
          s1_q <= s1_d;
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid)
          out_posit <= res;
      end
    end
  end
endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Directed and streamed checks of the posit packer against hand values and a bit-string model.
module tb_posit_encoder_pipe;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, in_sign, in_zero, in_nar, in_sticky;
  logic [3:0] in_k;
  logic [0:0] in_exp;
  logic [4:0] in_frac;
  logic       out_valid, out_ready;
  logic [7:0] out_posit;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic s, z, n;
    logic [3:0] k;
    logic e;
    logic [4:0] f;
    logic st;
  } vec_t;

  vec_t q[$];

  posit_encoder_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_zero(in_zero), .in_nar(in_nar), .in_k(in_k),
    .in_exp(in_exp), .in_frac(in_frac), .in_sticky(in_sticky),
    .out_valid(out_valid), .out_ready(out_ready), .out_posit(out_posit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Builds the posit body as an explicit bit string, independent of the RTL's shift scheme.
  function automatic logic [7:0] ref_enc(input vec_t v);
    int k, len, keep, g, st, p;
    longint bits;
    k = int'($signed(v.k));
    if (v.n) return 8'h80;
    if (v.z) return 8'h00;
    if (k >= 6) p = 8'h7f;
    else if (k <= -6) p = 8'h01;
    else begin
      bits = 0;
      if (k >= 0) begin
        for (int i = 0; i < k + 1; i++) bits = (bits << 1) | 1;
        bits = bits << 1;
        len = k + 2;
      end else begin
        bits = 1;
        len = -k + 1;
      end
      bits = (bits << 1) | longint'(v.e);
      bits = (bits << 5) | longint'(v.f);
      len += 6;
      keep = int'(bits >> (len - 7));
      g    = int'((bits >> (len - 8)) & 1);
      st   = (((bits & ((longint'(1) << (len - 8)) - 1)) != 0) || v.st) ? 1 : 0;
      if (g == 1 && ((keep & 1) == 1 || st == 1)) keep++;
      if (keep > 127) keep = 127;
      if (keep == 0) keep = 1;
      p = keep;
    end
    if (v.s) p = (256 - p) & 255;
    return 8'(p);
  endfunction

  task automatic drive(input vec_t v);
    in_sign = v.s; in_zero = v.z; in_nar = v.n; in_k = v.k;
    in_exp = v.e; in_frac = v.f; in_sticky = v.st;
  endtask

  function automatic vec_t mk(input logic s, z, n, input logic [3:0] k, input logic e,
                              input logic [4:0] f, input logic st);
    vec_t v;
    v.s = s; v.z = z; v.n = n; v.k = k; v.e = e; v.f = f; v.st = st;
    return v;
  endfunction

  // Single word with out_ready high; checks the 2-cycle latency and the value.
  task automatic run1(input string tag, input vec_t v, input logic [7:0] exp);
    drive(v);
    in_valid = 1'b1;
    #1 chk({tag, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_v1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_v2"}, out_valid, 1);
    chk(tag, out_posit, exp);
    @(negedge clk);
  endtask

  // Streams q[] with out_ready low for the first `stall` cycles; all outputs checked in order.
  task automatic run_stream(input string tag, input int stall, input bit chk_lat);
    int sent, got, cyc, nw;
    int acc[$];
    sent = 0; got = 0; cyc = 0; nw = q.size();
    while (got < nw && cyc < 200) begin
      out_ready = (cyc >= stall);
      if (sent < nw) begin
        drive(q[sent]);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (stall > 0 && cyc == 2) begin
        chk({tag, "_bp_rdy"}, in_ready, 0);
        chk({tag, "_bp_sent"}, sent, 2);
        chk({tag, "_bp_vld"}, out_valid, 1);
      end
      if (stall > 0 && cyc > 0 && cyc < stall && out_valid)
        chk({tag, "_bp_hold"}, out_posit, ref_enc(q[0]));
      if (out_valid && out_ready) begin
        chk(tag, out_posit, ref_enc(q[got]));
        if (chk_lat) chk({tag, "_lat"}, cyc, acc[got] + 2);
        got++;
      end
      if (in_valid && in_ready) begin
        acc.push_back(cyc);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, got, nw);
    for (int i = 0; i < 3; i++) begin
      #1 chk({tag, "_nodup"}, out_valid, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(mk(0, 0, 0, 4'd0, 1'b0, 5'd0, 0));
    @(negedge clk); @(negedge clk);
    chk("rst_vld", out_valid, 0);
    chk("rst_posit", out_posit, 8'h00);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", in_ready, 1);

    run1("basic_k0",   mk(0, 0, 0, 4'd0,  1'b0, 5'b00000, 0), 8'h40);
    run1("basic_k1",   mk(0, 0, 0, 4'd1,  1'b1, 5'b00000, 0), 8'h68);
    run1("basic_neg",  mk(1, 0, 0, 4'd0,  1'b0, 5'b00000, 0), 8'hC0);
    run1("rnd_up",     mk(0, 0, 0, 4'd0,  1'b0, 5'b00011, 0), 8'h42);
    run1("rnd_tie",    mk(0, 0, 0, 4'd0,  1'b0, 5'b00001, 0), 8'h40);
    run1("rnd_sticky", mk(0, 0, 0, 4'd0,  1'b0, 5'b00001, 1), 8'h41);
    run1("sat_k6",     mk(0, 0, 0, 4'd6,  1'b0, 5'b00000, 0), 8'h7F);
    run1("sat_k7_neg", mk(1, 0, 0, 4'd7,  1'b0, 5'b00000, 0), 8'h81);
    run1("sat_km6",    mk(0, 0, 0, 4'hA,  1'b0, 5'b00000, 0), 8'h01);
    run1("sat_km7",    mk(0, 0, 0, 4'h9,  1'b0, 5'b00000, 0), 8'h01);
    run1("km5_e1",     mk(0, 0, 0, 4'hB,  1'b1, 5'b00000, 0), 8'h03);
    run1("k5_rnd_max", mk(0, 0, 0, 4'd5,  1'b1, 5'b00001, 0), 8'h7F);
    run1("zero",       mk(1, 1, 0, 4'd3,  1'b1, 5'b10101, 0), 8'h00);
    run1("nar",        mk(0, 1, 1, 4'd2,  1'b0, 5'b00000, 0), 8'h80);

    q.delete();
    q.push_back(mk(0, 0, 0, 4'd0, 1'b0, 5'b00000, 0));
    q.push_back(mk(0, 0, 0, 4'd1, 1'b1, 5'b00000, 0));
    q.push_back(mk(1, 0, 0, 4'd0, 1'b0, 5'b00000, 0));
    q.push_back(mk(0, 0, 0, 4'd0, 1'b0, 5'b00011, 0));
    run_stream("bp", 3, 0);

    q.delete();
    for (int i = 0; i < 16; i++)
      q.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
                     1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1))));
    run_stream("tput", 0, 1);

    // Fill both stages, then reset.
    out_ready = 1'b0;
    drive(mk(0, 0, 0, 4'd1, 1'b1, 5'b00000, 0));
    in_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_posit", out_posit, 8'h00);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_nostale", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
